// File: rtl/mem_access_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the memory-access pipeline stage: data/exception
// widths, opcode and funct3 encodings, exception codes, FSM state type,
// the captured-request context struct and small access-size helpers.
// ---------------------------------------------------------------------------
package mem_access_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned EXW_DEF  = 4;
    localparam int unsigned OPC_W    = 5;
    localparam int unsigned F3_W     = 3;
    localparam int unsigned RA_W     = 5;
    localparam int unsigned BE_W     = 4;

    // instr[6:2] opcode encodings
    localparam logic [OPC_W-1:0] OP_LOAD   = 5'b00000;
    localparam logic [OPC_W-1:0] OP_IMM    = 5'b00100;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_STORE  = 5'b01000;
    localparam logic [OPC_W-1:0] OP_OP     = 5'b01100;
    localparam logic [OPC_W-1:0] OP_LUI    = 5'b01101;
    localparam logic [OPC_W-1:0] OP_BRANCH = 5'b11000;
    localparam logic [OPC_W-1:0] OP_JALR   = 5'b11001;
    localparam logic [OPC_W-1:0] OP_JAL    = 5'b11011;
    localparam logic [OPC_W-1:0] OP_SYSTEM = 5'b11100;

    // funct3 width encodings
    localparam logic [F3_W-1:0] F3_LB  = 3'b000;
    localparam logic [F3_W-1:0] F3_LH  = 3'b001;
    localparam logic [F3_W-1:0] F3_LW  = 3'b010;
    localparam logic [F3_W-1:0] F3_LBU = 3'b100;
    localparam logic [F3_W-1:0] F3_LHU = 3'b101;
    localparam logic [F3_W-1:0] F3_SB  = 3'b000;
    localparam logic [F3_W-1:0] F3_SH  = 3'b001;
    localparam logic [F3_W-1:0] F3_SW  = 3'b010;

    // exception codes raised by this stage
    localparam int unsigned EXC_LOAD_MISALIGN  = 4;
    localparam int unsigned EXC_LOAD_FAULT     = 5;
    localparam int unsigned EXC_STORE_MISALIGN = 6;
    localparam int unsigned EXC_STORE_FAULT    = 7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_e;

    // instruction context held while a memory transaction is outstanding
    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [F3_W-1:0]  funct3;
        logic [RA_W-1:0]  rd_addr;
        logic             is_store;
    } mem_ctx_t;

    // Access size from funct3; unknown encodings behave as word accesses.
    function automatic acc_size_e access_size(input logic is_store, input logic [F3_W-1:0] f3);
        acc_size_e sz;
        sz = SZ_WORD;
        if (is_store) begin
            case (f3)
                F3_SB:   sz = SZ_BYTE;
                F3_SH:   sz = SZ_HALF;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LBU: sz = SZ_BYTE;
                F3_LH, F3_LHU: sz = SZ_HALF;
                default:       sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

    function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] addr_lo);
        logic mis;
        case (sz)
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// ---------------------------------------------------------------------------
// mem_load_align
// Combinational load aligner: picks the byte/halfword addressed by
// i_addr_lo out of the returned word and sign- or zero-extends it.
// Ports:
//   i_rdata   in  XLEN  word returned by data memory
//   i_addr_lo in  2     low address bits of the access
//   i_funct3  in  3     load width/signedness; unknown -> full word
//   o_data    out XLEN  extended load value
// ---------------------------------------------------------------------------
module mem_load_align
    import mem_access_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_addr_lo,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        // halfword accesses reaching memory are always 2-byte aligned
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_funct3)
            F3_LB:   o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LBU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
            F3_LH:   o_data = {{(XLEN-16){w_half[15]}}, w_half};
            F3_LHU:  o_data = {{(XLEN-16){1'b0}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access
// Memory-access pipeline stage between execute and writeback. Issues at most
// one data-memory transaction per load/store, stalls execute while it is
// outstanding, aligns load data and presents a one-cycle writeback bundle.
// Ports:
//   clk, reset                   clock, async active-high reset
//   in_*                         instruction from execute (in_valid qualifies)
//   stall                        execute must hold its outputs
//   dmem_req/we/addr/wdata/be    registered memory request, stable until ack
//   dmem_ack/rdata/err           memory response
//   opcode..exception            writeback bundle, qualified by pipeline_valid
// ---------------------------------------------------------------------------
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned EXW  = EXW_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [4:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic            in_nop,
    input  logic [XLEN-1:0] in_result,
    input  logic [XLEN-1:0] in_store_data,
    input  logic [4:0]      in_rd_addr,
    input  logic            in_exception_valid,
    input  logic [EXW-1:0]  in_exception,
    output logic            stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_err,
    output logic [4:0]      opcode,
    output logic            nop_instr,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_addr,
    output logic            exception_valid,
    output logic [EXW-1:0]  exception,
    output logic            pipeline_valid
);

    state_e          r_state;
    state_e          w_state_next;

    mem_ctx_t        r_ctx;
    logic [XLEN-1:0] r_addr;
    logic            r_dmem_we;
    logic [XLEN-1:0] r_dmem_addr;
    logic [XLEN-1:0] r_dmem_wdata;
    logic [3:0]      r_dmem_be;

    logic [4:0]      r_opcode;
    logic            r_nop_instr;
    logic [XLEN-1:0] r_result;
    logic [4:0]      r_rd_addr;
    logic            r_exception_valid;
    logic [EXW-1:0]  r_exception;
    logic            r_pipeline_valid;

    logic            w_is_load;
    logic            w_is_store;
    logic            w_is_mem;
    acc_size_e       w_size;
    logic            w_misalign;
    logic            w_start_mem;
    logic [3:0]      w_st_be;
    logic [XLEN-1:0] w_st_wdata;
    logic [XLEN-1:0] w_load_data;

    logic            w_stall;
    logic            w_dmem_req;
    logic            w_capture;
    logic            w_out_load;
    logic [4:0]      w_nxt_opcode;
    logic            w_nxt_nop;
    logic [XLEN-1:0] w_nxt_result;
    logic [4:0]      w_nxt_rd_addr;
    logic            w_nxt_exc_valid;
    logic [EXW-1:0]  w_nxt_exc;

    mem_load_align #(.XLEN(XLEN)) u_load_align (
        .i_rdata   (dmem_rdata),
        .i_addr_lo (r_addr[1:0]),
        .i_funct3  (r_ctx.funct3),
        .o_data    (w_load_data)
    );

    // Incoming instruction classification; bubbles and upstream faults never touch memory.
    always_comb begin
        w_is_load   = (in_opcode == OP_LOAD);
        w_is_store  = (in_opcode == OP_STORE);
        w_is_mem    = w_is_load || w_is_store;
        w_size      = access_size(w_is_store, in_funct3);
        w_misalign  = w_is_mem && !in_nop && !in_exception_valid
                      && is_misaligned(w_size, in_result[1:0]);
        w_start_mem = w_is_mem && !in_nop && !in_exception_valid && !w_misalign;
    end

    // Store byte-lane steering: data replicated so every enabled lane carries it.
    always_comb begin
        case (w_size)
            SZ_BYTE: begin
                w_st_be    = 4'b0001 << in_result[1:0];
                w_st_wdata = XLEN'({4{in_store_data[7:0]}});
            end
            SZ_HALF: begin
                w_st_be    = 4'b0011 << in_result[1:0];
                w_st_wdata = XLEN'({2{in_store_data[15:0]}});
            end
            default: begin
                w_st_be    = 4'b1111;
                w_st_wdata = in_store_data;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid && w_start_mem) w_state_next = ST_BUSY;
            ST_BUSY: if (dmem_ack)                w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output/control decode and next writeback bundle
    always_comb begin
        w_stall         = 1'b0;
        w_dmem_req      = 1'b0;
        w_capture       = 1'b0;
        w_out_load      = 1'b0;
        w_nxt_opcode    = '0;
        w_nxt_nop       = 1'b0;
        w_nxt_result    = '0;
        w_nxt_rd_addr   = '0;
        w_nxt_exc_valid = 1'b0;
        w_nxt_exc       = '0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (w_start_mem) begin
                        w_capture = 1'b1;
                    end else begin
                        w_out_load      = 1'b1;
                        w_nxt_opcode    = in_opcode;
                        w_nxt_nop       = in_nop;
                        w_nxt_result    = in_result;
                        w_nxt_rd_addr   = in_rd_addr;
                        w_nxt_exc_valid = in_exception_valid || w_misalign;
                        // upstream exception wins over a local misalignment
                        if (in_exception_valid)
                            w_nxt_exc = in_exception;
                        else if (w_misalign)
                            w_nxt_exc = w_is_store ? EXW'(EXC_STORE_MISALIGN)
                                                   : EXW'(EXC_LOAD_MISALIGN);
                    end
                end
            end
            ST_BUSY: begin
                w_stall    = 1'b1;
                w_dmem_req = 1'b1;
                if (dmem_ack) begin
                    w_out_load      = 1'b1;
                    w_nxt_opcode    = r_ctx.opcode;
                    w_nxt_result    = r_ctx.is_store ? r_addr : w_load_data;
                    w_nxt_rd_addr   = r_ctx.rd_addr;
                    w_nxt_exc_valid = dmem_err;
                    if (dmem_err)
                        w_nxt_exc = r_ctx.is_store ? EXW'(EXC_STORE_FAULT)
                                                   : EXW'(EXC_LOAD_FAULT);
                end
            end
            default: ;
        endcase
    end

    // Request capture and writeback bundle registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctx             <= '0;
            r_addr            <= '0;
            r_dmem_we         <= 1'b0;
            r_dmem_addr       <= '0;
            r_dmem_wdata      <= '0;
            r_dmem_be         <= '0;
            r_opcode          <= '0;
            r_nop_instr       <= 1'b0;
            r_result          <= '0;
            r_rd_addr         <= '0;
            r_exception_valid <= 1'b0;
            r_exception       <= '0;
            r_pipeline_valid  <= 1'b0;
        end else begin
            r_pipeline_valid <= w_out_load;
            if (w_capture) begin
                r_ctx        <= '{opcode: in_opcode, funct3: in_funct3,
                                  rd_addr: in_rd_addr, is_store: w_is_store};
                r_addr       <= in_result;
                r_dmem_we    <= w_is_store;
                r_dmem_addr  <= {in_result[XLEN-1:2], 2'b00};
                r_dmem_wdata <= w_is_store ? w_st_wdata : '0;
                r_dmem_be    <= w_is_store ? w_st_be : 4'b1111;
            end
            if (w_out_load) begin
                r_opcode          <= w_nxt_opcode;
                r_nop_instr       <= w_nxt_nop;
                r_result          <= w_nxt_result;
                r_rd_addr         <= w_nxt_rd_addr;
                r_exception_valid <= w_nxt_exc_valid;
                r_exception       <= w_nxt_exc;
            end
        end
    end

    // stall/dmem_req decode the state flop only, so reset drops them at once
    assign stall           = w_stall;
    assign dmem_req        = w_dmem_req;
    assign dmem_we         = r_dmem_we;
    assign dmem_addr       = r_dmem_addr;
    assign dmem_wdata      = r_dmem_wdata;
    assign dmem_be         = r_dmem_be;
    assign opcode          = r_opcode;
    assign nop_instr       = r_nop_instr;
    assign result          = r_result;
    assign rd_addr         = r_rd_addr;
    assign exception_valid = r_exception_valid;
    assign exception       = r_exception;
    assign pipeline_valid  = r_pipeline_valid;

endmodule
